// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the program/data memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF           = 13;
  localparam int DW_DEF           = 8;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // The counter needs to hold values from 0 up to and including the limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core, host and memory port bundle.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);

  logic          CORE_RD;
  logic          CORE_WR;
  logic [AW-1:0] CORE_ADDR;
  logic [DW-1:0] CORE_WDATA;
  logic [DW-1:0] CORE_RDATA;
  logic          CORE_HOLD;

  logic          HOST_REQ;
  logic          HOST_WE;
  logic [AW-1:0] HOST_ADDR;
  logic [DW-1:0] HOST_WDATA;
  logic          HOST_ACK;
  logic [DW-1:0] HOST_RDATA;
  logic          HOST_RVALID;

  logic          MEM_EN;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  logic          BUS_ERR;

  modport slave (
    input  CORE_RD, CORE_WR, CORE_ADDR, CORE_WDATA,
    input  HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    input  MEM_RDATA,
    output CORE_RDATA, CORE_HOLD,
    output HOST_ACK, HOST_RDATA, HOST_RVALID,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    output BUS_ERR
  );

  modport master (
    output CORE_RD, CORE_WR, CORE_ADDR, CORE_WDATA,
    output HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    output MEM_RDATA,
    input  CORE_RDATA, CORE_HOLD,
    input  HOST_ACK, HOST_RDATA, HOST_RVALID,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  BUS_ERR
  );

endinterface

// File: rtl/starve_timer.sv
// Saturating wait counter for the host port; reached flags the saturation value.
module starve_timer
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic reached
);

  localparam int             CW      = cnt_width(LIMIT);
  localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count;

  // Count waiting cycles, holding at the limit until cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != LIMIT_C)) begin
      count <= count + CW'(1);
    end
  end

  assign reached = (count == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data memory between the core and the host port.
// The core always wins; the host uses core-idle cycles, with a hold request to
// the core once the host has waited long enough.
//
//  state | meaning
//  IDLE  | no host read outstanding; host may issue in a core-idle cycle
//  RESP  | host read data on MEM_RDATA this cycle; captured at the edge
//  HOLD  | CORE_HOLD asserted; host issues on the first core-idle cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state;
  logic       core_req;
  logic       host_issue;
  logic       starve_clr;
  logic       starved;

  assign core_req   = bus.CORE_RD | bus.CORE_WR;
  // Host never issues during reset so MEM_* only reflect the core then.
  assign host_issue = bus.HOST_REQ & ~core_req & ~SYS_RST & (state != RESP);

  assign bus.HOST_ACK   = host_issue;
  assign bus.CORE_RDATA = bus.MEM_RDATA;

  // Port mux: core first; a simultaneous RD+WR becomes a plain read.
  always_comb begin
    bus.MEM_EN    = 1'b0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_ADDR  = {AW{1'b0}};
    bus.MEM_WDATA = {DW{1'b0}};
    if (core_req) begin
      bus.MEM_EN    = 1'b1;
      bus.MEM_WE    = bus.CORE_WR & ~bus.CORE_RD;
      bus.MEM_ADDR  = bus.CORE_ADDR;
      bus.MEM_WDATA = bus.CORE_WDATA;
    end else if (host_issue) begin
      bus.MEM_EN    = 1'b1;
      bus.MEM_WE    = bus.HOST_WE;
      bus.MEM_ADDR  = bus.HOST_ADDR;
      bus.MEM_WDATA = bus.HOST_WDATA;
    end
  end

  assign starve_clr = ~bus.HOST_REQ | host_issue;

  starve_timer #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_timer (
    .clk     (SYS_CLK),
    .rst     (SYS_RST),
    .clr     (starve_clr),
    .inc     (bus.HOST_REQ),
    .reached (starved)
  );

  // Arbitration FSM with registered hold, read-return and error outputs.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state           <= IDLE;
      bus.CORE_HOLD   <= 1'b0;
      bus.HOST_RVALID <= 1'b0;
      bus.HOST_RDATA  <= {DW{1'b0}};
      bus.BUS_ERR     <= 1'b0;
    end else begin
      bus.HOST_RVALID <= 1'b0;
      if (bus.CORE_RD && bus.CORE_WR) begin
        bus.BUS_ERR <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (host_issue) begin
            state <= bus.HOST_WE ? IDLE : RESP;
          end else if (bus.HOST_REQ && starved) begin
            state         <= HOLD;
            bus.CORE_HOLD <= 1'b1;
          end
        end
        RESP: begin
          bus.HOST_RDATA  <= bus.MEM_RDATA;
          bus.HOST_RVALID <= 1'b1;
          state           <= IDLE;
        end
        HOLD: begin
          if (!bus.HOST_REQ) begin
            state         <= IDLE;
            bus.CORE_HOLD <= 1'b0;
          end else if (host_issue) begin
            state         <= bus.HOST_WE ? IDLE : RESP;
            bus.CORE_HOLD <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.CORE_HOLD <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single-port 8K×8 program/data memory. It shares the memory port between the CPU core's bus (MEM_RD/MEM_WR/ADDRESS/DATA side, split into unidirectional signals) and a host/debug port used for program loading and memory inspection. The core has fixed priority because it cannot stall. The host is served in core-idle cycles. A starvation timer can request a core hold so the host always completes.

## Interface
- AW, 13, address width
- DW, 8, data width
- STARVE_LIMIT, 8, host wait cycles before CORE_HOLD is raised (≥1)

- SYS_CLK  in  1  single clock, rising edge
- SYS_RST  in  1  synchronous, active-high reset
- CORE_RD  in  1  core read request, level, this cycle
- CORE_WR  in  1  core write request, level, this cycle
- CORE_ADDR  in  AW  core address
- CORE_WDATA  in  DW  core write data
- CORE_RDATA  out  DW  memory read data to core (pass-through of MEM_RDATA)
- CORE_HOLD  out  1  registered request to freeze the core's control FSM
- HOST_REQ  in  1  host request, held until HOST_ACK
- HOST_WE  in  1  1 = write, 0 = read
- HOST_ADDR  in  AW  host address
- HOST_WDATA  in  DW  host write data
- HOST_ACK  out  1  one-cycle pulse: host access issued to memory this cycle
- HOST_RDATA  out  DW  registered host read data
- HOST_RVALID  out  1  one-cycle pulse: HOST_RDATA valid
- MEM_EN  out  1  memory enable
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  AW  memory address
- MEM_WDATA  out  DW  memory write data
- MEM_RDATA  in  DW  sync-RAM read data, 1 cycle after the enabled read
- BUS_ERR  out  1  sticky: core asserted RD and WR together

## Operation
- States: IDLE, RESP, HOLD.
- Port mux is combinational. Core wins whenever CORE_RD|CORE_WR, in every state.
- CORE_RD and CORE_WR both high: perform the read, suppress the write, set BUS_ERR. BUS_ERR clears only on reset.
- IDLE or HOLD, HOST_REQ=1, core idle:
  - Drive MEM_* from the host port and pulse HOST_ACK.
  - Write: stay in or return to IDLE.
  - Read: go to RESP.
- RESP, one cycle: capture MEM_RDATA into HOST_RDATA, then go to IDLE. No host issue in RESP. Core accesses are still permitted.
- Starvation counter:
  - Counts cycles with HOST_REQ=1 and no HOST_ACK. Saturates at STARVE_LIMIT.
  - Clears on HOST_ACK or when HOST_REQ drops.
  - When the count reaches STARVE_LIMIT in IDLE: go to HOLD and set CORE_HOLD.
- HOLD:
  - Wait for the first core-idle cycle, then issue the host access.
  - CORE_HOLD deasserts the cycle after HOST_ACK.
- HOST_REQ withdrawn before ACK: request dropped, counter cleared. From HOLD, return to IDLE and deassert CORE_HOLD next cycle.
- CORE_RDATA = MEM_RDATA at all times. The core ignores it on cycles it did not read.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - CORE_HOLD, HOST_ACK, HOST_RVALID, BUS_ERR = 0.
  - HOST_RDATA = 0.
  - MEM_EN/MEM_WE = 0 unless the core is requesting.
- Reset mid-transaction aborts it: no RVALID is produced, CORE_HOLD drops the cycle after reset.
- Host write issued in cycle t completes at the t edge. Back-to-back writes: ACK possible every cycle.
- Host read issued in cycle t:
  - MEM_RDATA is valid in cycle t+1 and registered at the t+1 edge.
  - HOST_RVALID=1 in cycle t+2.
  - Next host ACK no earlier than t+2.
- The host holds HOST_WE/ADDR/WDATA stable while HOST_REQ=1 and ACK=0.
- CORE_HOLD: rises in the cycle after the counter reaches STARVE_LIMIT. Worst-case host wait with a cooperating core is STARVE_LIMIT+2 cycles.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, RESP, HOLD}
  - AW/DW defaults
  - counter width = $clog2(STARVE_LIMIT+1)
- One sub-module: `starve_timer`. Saturating counter with clear input; output is reached = (count == STARVE_LIMIT).

## Test plan
- Core-only reads and writes to 0x0000, 0x1FFF and 0x0AAA with HOST_REQ=0 → MEM_* mirrors the core each cycle, CORE_RDATA follows MEM_RDATA, HOST_ACK never pulses.
- Host writes 0x5A to 0x0010, then reads 0x0010 with the core idle → ACK in cycles t and t+2; HOST_RVALID in t+4 with HOST_RDATA=0x5A.
- Core reads every cycle, HOST_REQ read of 0x0020, STARVE_LIMIT=8:
  - CORE_HOLD rises after 8 waiting cycles.
  - The bench core goes idle → ACK on the first idle cycle, RVALID 2 cycles later, CORE_HOLD low the cycle after ACK.
- Core and host both request in the same cycle → core access on MEM_*, no HOST_ACK, host served the next idle cycle.
- CORE_RD=CORE_WR=1 at 0x0100 → MEM_WE=0, read performed, BUS_ERR=1 and it stays 1 until SYS_RST.
- Reset cases:
  - SYS_RST asserted in RESP → no HOST_RVALID, all outputs at reset values next cycle.
  - HOST_REQ withdrawn while in HOLD → CORE_HOLD low the next cycle, state IDLE.
